// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader:
// FSM state encoding, error codes and default widths.
package program_loader_pkg;

    // Default geometry: 256 x 8-bit instruction words.
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    // Loader FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    // Values reported on err_code.
    localparam logic [1:0] ERR_NONE = 2'd0;  // no error
    localparam logic [1:0] ERR_LEN  = 2'd1;  // load_len of 0 or larger than the memory
    localparam logic [1:0] ERR_SUM  = 2'd2;  // readback or image checksum mismatch

endpackage : program_loader_pkg

// File: rtl/loader_checksum.sv
// Running modulo-2**DATA_W sum with synchronous clear and enable.
// Used once for the write-side sum and once for the readback sum.
module loader_checksum
    import program_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] sum_next;

    // Next sum: clear wins over accumulate; the adder wraps silently.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        sum_next = sum;
        if (clear) begin
            sum_next = '0;
        end else if (enable) begin
            sum_next = sum + din;
        end
    end

    // Sum register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            sum <= '0;
        end else begin
            sum <= sum_next;
        end
    end

endmodule : loader_checksum

// File: rtl/program_loader.sv
// Program loader: streams an image into the instruction RAM, reads it back,
// checks both sums against the host's expected sum, and only then releases
// the microprocessor from reset.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic [DATA_W-1:0] exp_sum,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    // Counters are one bit wider than the address so a full-depth length fits.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   len_q;
    logic [DATA_W-1:0] exp_q;
    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W:0]   rd_cnt;
    logic              rd_valid;
    logic [1:0]        err_q;
    logic [DATA_W-1:0] wsum;
    logic [DATA_W-1:0] rsum;
    logic [DATA_W-1:0] rsum_final;

    logic start_seen;
    logic len_bad;
    logic start_ok;
    logic start_bad;
    logic beat;
    logic last_wr;
    logic last_rd;
    logic sum_ok;

    // load_start only counts in the resting states; elsewhere it is ignored.
    assign start_seen = load_start &&
                        (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    assign len_bad    = (load_len == '0) || (load_len > DEPTH_W);
    assign start_ok   = start_seen && !len_bad;
    assign start_bad  = start_seen && len_bad;

    // A write beat is the stream handshake while loading (in_ready is 1 throughout LOAD).
    assign beat    = (state == ST_LOAD) && in_valid;
    assign last_wr = beat && (wr_cnt == len_q - ONE);
    assign last_rd = (state == ST_VERIFY) && (rd_cnt == len_q - ONE);

    // In DRAIN the final read beat is on mem_rdata but not yet in rsum,
    // so the comparison folds it in directly.
    assign rsum_final = rsum + mem_rdata;
    assign sum_ok     = (rsum_final == wsum) && (wsum == exp_q);

    assign err_code = err_q;

    // Write-side sum of every accepted stream byte.
    loader_checksum #(.DATA_W(DATA_W)) u_wsum (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_ok),
        .enable (beat),
        .din    (in_data),
        .sum    (wsum)
    );

    // Readback sum, fed one cycle after each read is issued.
    loader_checksum #(.DATA_W(DATA_W)) u_rsum (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_ok),
        .enable (rd_valid),
        .din    (mem_rdata),
        .sum    (rsum)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and all memory/status outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_hold   = 1'b1;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                done     = (state == ST_DONE);
                error    = (state == ST_ERROR);
                cpu_hold = (state != ST_DONE);
                if (start_bad) begin
                    state_next = ST_ERROR;
                end else if (start_ok) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                mem_addr = wr_cnt[ADDR_W-1:0];
                if (beat) begin
                    mem_we    = 1'b1;
                    mem_wdata = in_data;
                end
                if (last_wr) begin
                    state_next = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                busy     = 1'b1;
                mem_re   = 1'b1;
                mem_addr = rd_cnt[ADDR_W-1:0];
                if (last_rd) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy       = 1'b1;
                state_next = sum_ok ? ST_DONE : ST_ERROR;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Counters, latched job parameters, read-valid pipe and error code.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: reset clears only the loader's own registers; the instruction RAM is external and keeps whatever it holds.
        if (!reset) begin
            len_q    <= '0;
            exp_q    <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            rd_valid <= 1'b0;
            err_q    <= ERR_NONE;
        end else begin
            rd_valid <= mem_re;
            if (start_ok) begin
                len_q  <= load_len;
                exp_q  <= exp_sum;
                wr_cnt <= '0;
                rd_cnt <= '0;
                err_q  <= ERR_NONE;
            end else begin
                if (start_bad) begin
                    err_q <= ERR_LEN;
                end
                if (beat) begin
                    wr_cnt <= wr_cnt + ONE;
                end
                // Stop at len-1 so a full-depth read never steps past DEPTH-1.
                if (state == ST_VERIFY && !last_rd) begin
                    rd_cnt <= rd_cnt + ONE;
                end
                if (state == ST_DRAIN && !sum_ok) begin
                    err_q <= ERR_SUM;
                end
            end
        end
    end

endmodule : program_loader

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a synchronous RAM model with an
// optional corrupted readback, and a scoreboard of expected write and read
// addresses pushed when a load is driven and popped as the strobes appear.
module tb_program_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 256;

    logic              clk        = 1'b0;
    logic              reset      = 1'b0;
    logic              load_start = 1'b0;
    logic [ADDR_W:0]   load_len   = '0;
    logic [DATA_W-1:0] exp_sum    = '0;
    logic              in_valid   = 1'b0;
    logic [DATA_W-1:0] in_data    = '0;
    logic              in_ready;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata  = '0;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;
    bit corrupt  = 1'b0;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] img [DEPTH];
    logic [15:0]       wr_q [$];
    logic [7:0]        rd_q [$];

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_len   (load_len),
        .exp_sum    (exp_sum),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Instruction RAM model; address 2 optionally reads back with bit 0 flipped.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr] ^ ((corrupt && mem_addr == 8'd2) ? 8'h01 : 8'h00);
    end

    // Strobe monitor: pops the scoreboard mid-cycle, after inputs have settled.
    always @(negedge clk) begin
        logic [15:0] e;
        #2;
        if (mem_we) begin
            if (wr_q.size() == 0) check("wr_unexpected", {mem_addr, mem_wdata}, 16'hxxxx);
            else begin
                e = wr_q.pop_front();
                check("wr_addr_data", {mem_addr, mem_wdata}, e);
            end
        end
        if (mem_re) begin
            if (rd_q.size() == 0) check("rd_unexpected", mem_addr, 32'hxx);
            else check("rd_addr", mem_addr, rd_q.pop_front());
        end
        if (mem_we && mem_re) check("we_re_overlap", 1, 0);
    end

    // Runs one valid load: queues expectations, pulses load_start, streams the
    // image (optionally with 1,0,1,0 valid gaps and a stray load_start mid-load)
    // and waits for DONE or ERROR.
    task automatic do_load(input int n, input logic [7:0] es, input bit gaps,
                           input bit poke, input int exp_lat);
        int idx = 0;
        int guard = 0;
        int t0;
        bit phase = 1'b0;
        bit acc;
        for (int i = 0; i < n; i++) begin
            wr_q.push_back({8'(i), img[i]});
            rd_q.push_back(8'(i));
        end
        load_len   = (ADDR_W+1)'(n);
        exp_sum    = es;
        load_start = 1'b1;
        t0 = cyc_cnt;
        @(negedge clk);
        load_start = 1'b0;
        check("start_state", {busy, cpu_hold, done, error}, 4'b1100);
        while (idx < n && guard < 4 * DEPTH) begin
            load_start = poke && (guard == 50);
            if (gaps && phase) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = img[idx];
            end
            if (gaps) phase = !phase;
            #1 acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) idx++;
            guard++;
        end
        in_valid   = 1'b0;
        load_start = 1'b0;
        check("feed_count", idx, n);
        guard = 0;
        while (!(done || error) && guard < 4 * DEPTH) begin
            @(negedge clk);
            guard++;
        end
        check("finish_seen", done || error, 1);
        if (exp_lat > 0) check("latency", cyc_cnt - t0, exp_lat);
        check("wr_q_empty", wr_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);
    endtask

    // Pulses load_start with a rejected length and checks the ERROR entry.
    task automatic bad_load(input int n);
        load_len   = (ADDR_W+1)'(n);
        exp_sum    = 8'h00;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("badlen_state", {busy, cpu_hold, done, error}, 4'b0101);
        check("badlen_code", err_code, 2'd1);
        // Stream bytes offered outside LOAD must be refused and never written.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) begin
            #1 check("badlen_no_ready", {in_ready, mem_we}, 2'b00);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_status", {cpu_hold, busy, done, error, err_code}, 6'b100000);
        check("rst_strobes", {in_ready, mem_we, mem_re}, 3'b000);
        check("rst_addr_data", {mem_addr, mem_wdata}, 16'h0000);

        // Four-byte image, continuous valid.
        img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56; img[3] = 8'h78;
        do_load(4, 8'h14, 1'b0, 1'b0, 10);
        check("a_done", {done, error, cpu_hold, err_code}, 5'b10000);

        // Same image with gaps in the stream.
        do_load(4, 8'h14, 1'b1, 1'b0, 0);
        check("b_done", {done, error, cpu_hold, err_code}, 5'b10000);

        // Corrupted readback at address 2.
        corrupt = 1'b1;
        do_load(4, 8'h14, 1'b0, 1'b0, 10);
        corrupt = 1'b0;
        check("c_error", {done, error, cpu_hold, err_code}, 5'b01110);

        // Zero length from ERROR; then a good load clears the code; then 257.
        bad_load(0);
        do_load(4, 8'h14, 1'b0, 1'b0, 10);
        check("d_done", {done, err_code}, 3'b100);
        bad_load(257);

        // Full-depth incrementing image with a stray load_start mid-load.
        for (int i = 0; i < DEPTH; i++) img[i] = 8'(i);
        do_load(DEPTH, 8'h80, 1'b0, 1'b1, 2 * DEPTH + 2);
        check("e_done", {done, error, cpu_hold, err_code}, 5'b10000);
        check("e_mem_first", mem[0], 8'h00);
        check("e_mem_last", mem[255], 8'hFF);

        // Reset asserted mid-LOAD while a byte is being offered.
        img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'h56;
        for (int i = 0; i < 3; i++) wr_q.push_back({8'(i), img[i]});
        load_len   = 9'd4;
        exp_sum    = 8'h14;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = img[i];
            if (i < 2) @(negedge clk);
        end
        #3 reset = 1'b0;
        #1;
        check("midrst_status", {cpu_hold, busy, done, error, err_code}, 6'b100000);
        check("midrst_strobes", {in_ready, mem_we, mem_re}, 3'b000);
        check("midrst_addr", mem_addr, 8'h00);
        check("midrst_wr_q", wr_q.size(), 0);
        in_valid = 1'b0;
        wr_q.delete();
        rd_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {cpu_hold, busy, done, error}, 4'b1000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_program_loader
